// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, datapath
// select encodings, condition codes and the data-processing command decode.
package mc_ctrl_pkg;

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_e;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_EOR = 3'b100;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_WD   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] OP_DP  = 2'b00;
    localparam logic [SEL_W-1:0] OP_MEM = 2'b01;
    localparam logic [SEL_W-1:0] OP_BR  = 2'b10;

    localparam logic [COND_W-1:0] CC_EQ = 4'b0000;
    localparam logic [COND_W-1:0] CC_NE = 4'b0001;
    localparam logic [COND_W-1:0] CC_CS = 4'b0010;
    localparam logic [COND_W-1:0] CC_CC = 4'b0011;
    localparam logic [COND_W-1:0] CC_MI = 4'b0100;
    localparam logic [COND_W-1:0] CC_PL = 4'b0101;
    localparam logic [COND_W-1:0] CC_VS = 4'b0110;
    localparam logic [COND_W-1:0] CC_VC = 4'b0111;
    localparam logic [COND_W-1:0] CC_HI = 4'b1000;
    localparam logic [COND_W-1:0] CC_LS = 4'b1001;
    localparam logic [COND_W-1:0] CC_GE = 4'b1010;
    localparam logic [COND_W-1:0] CC_LT = 4'b1011;
    localparam logic [COND_W-1:0] CC_GT = 4'b1100;
    localparam logic [COND_W-1:0] CC_LE = 4'b1101;
    localparam logic [COND_W-1:0] CC_AL = 4'b1110;
    localparam logic [COND_W-1:0] CC_NV = 4'b1111;

    typedef struct packed {
        logic [ALUC_W-1:0] alu;
        logic              wb;
        logic              cv;
    } dp_cmd_t;

    // Funct[4:1] to ALU operation; unlisted codes run as ADD and are discarded
    function automatic dp_cmd_t decode_cmd(input logic [3:0] cmd);
        dp_cmd_t d;
        d = '{alu: ALU_ADD, wb: 1'b0, cv: 1'b0};
        case (cmd)
            4'b0100: d = '{alu: ALU_ADD, wb: 1'b1, cv: 1'b1};
            4'b0010: d = '{alu: ALU_SUB, wb: 1'b1, cv: 1'b1};
            4'b0000: d = '{alu: ALU_AND, wb: 1'b1, cv: 1'b0};
            4'b1100: d = '{alu: ALU_ORR, wb: 1'b1, cv: 1'b0};
            4'b0001: d = '{alu: ALU_EOR, wb: 1'b1, cv: 1'b0};
            4'b1010: d = '{alu: ALU_SUB, wb: 1'b0, cv: 1'b1};
            default: d = '{alu: ALU_ADD, wb: 1'b0, cv: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// Combinational condition evaluation of an instruction's Cond field against
// the {N,Z,C,V} flag register.
module mc_condcheck
    import mc_ctrl_pkg::*;
(
    input  logic [COND_W-1:0] i_cond,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_cond_ex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = i_flags[3];
    assign w_z  = i_flags[2];
    assign w_c  = i_flags[1];
    assign w_v  = i_flags[0];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            CC_EQ: o_cond_ex = w_z;
            CC_NE: o_cond_ex = ~w_z;
            CC_CS: o_cond_ex = w_c;
            CC_CC: o_cond_ex = ~w_c;
            CC_MI: o_cond_ex = w_n;
            CC_PL: o_cond_ex = ~w_n;
            CC_VS: o_cond_ex = w_v;
            CC_VC: o_cond_ex = ~w_v;
            CC_HI: o_cond_ex = w_c & ~w_z;
            CC_LS: o_cond_ex = ~w_c | w_z;
            CC_GE: o_cond_ex = w_ge;
            CC_LT: o_cond_ex = ~w_ge;
            CC_GT: o_cond_ex = ~w_z & w_ge;
            CC_LE: o_cond_ex = w_z | ~w_ge;
            CC_AL: o_cond_ex = 1'b1;
            CC_NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencing controller: main FSM, NZCV flag register and all
// datapath enables/selects. Optional byte access via MC_CTRL_BYTE_EN.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [FLAG_W-1:0]  ALUFlags,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               IRWrite,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic               ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [ALUC_W-1:0]  ALUControl,
    output logic [SEL_W-1:0]   ImmSrc,
    output logic [SEL_W-1:0]   RegSrc,
    output logic               RegWrite,
    output logic               OnlyByte
);

    state_e              r_state;
    logic [FLAG_W-1:0]   r_flags;

    logic [COND_W-1:0]   w_cond;
    logic [SEL_W-1:0]    w_op;
    logic [FUNCT_W-1:0]  w_funct;
    logic                w_rd_pc;
    logic                w_cond_ex;
    dp_cmd_t             w_cmd;
    logic                w_unused;

    logic                w_pc_write;
    logic                w_adr_src;
    logic                w_mem_write;
    logic                w_mem_read;
    logic                w_ir_write;
    logic [SEL_W-1:0]    w_result_src;
    logic                w_alu_src_a;
    logic [SEL_W-1:0]    w_alu_src_b;
    logic [ALUC_W-1:0]   w_alu_control;
    logic                w_reg_write;
    logic                w_only_byte;

    // Instr carries IR[31:12]: Cond, Op, Funct, Rn, Rd
    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_rd_pc  = (Instr[3:0] == 4'hF);
    assign w_cmd    = decode_cmd(w_funct[4:1]);
    assign w_unused = ^Instr[7:4];

    mc_condcheck u_condcheck (
        .i_cond    (w_cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // Sequencer and flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_flags <= '0;
        end else begin
            case (r_state)
                S_FETCH:  if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_cond_ex)                r_state <= S_FETCH;
                    else if (w_op == OP_DP)        r_state <= w_funct[5] ? S_EXECI : S_EXECR;
                    else if (w_op == OP_MEM)       r_state <= S_MEMADR;
                    else if (w_op == OP_BR)        r_state <= S_BRANCH;
                    else                           r_state <= S_FETCH;
                end
                S_EXECR, S_EXECI: begin
                    if (w_funct[0]) begin
                        r_flags[3:2] <= ALUFlags[3:2];
                        if (w_cmd.cv) r_flags[1:0] <= ALUFlags[1:0];
                    end
                    r_state <= w_cmd.wb ? S_ALUWB : S_FETCH;
                end
                S_MEMADR: r_state <= w_funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (MemReady) r_state <= S_MEMWB;
                S_MEMWR:  if (MemReady) r_state <= S_FETCH;
                S_ALUWB, S_MEMWB, S_BRANCH: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the current state; only the fetch enables follow MemReady
    always_comb begin
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_ir_write    = 1'b0;
        w_result_src  = RES_ALUOUT;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = SRCB_WD;
        w_alu_control = ALU_ADD;
        w_reg_write   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read   = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                w_ir_write   = MemReady;
                w_pc_write   = MemReady;
            end
            S_DECODE: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_FOUR;
            end
            S_EXECR: w_alu_control = w_cmd.alu;
            S_EXECI: begin
                w_alu_src_b   = SRCB_IMM;
                w_alu_control = w_cmd.alu;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_pc_write  = w_rd_pc;
            end
            S_MEMADR: w_alu_src_b = SRCB_IMM;
            S_MEMRD: begin
                w_adr_src  = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_pc_write   = w_rd_pc;
            end
            S_MEMWR: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_b  = SRCB_IMM;
                w_result_src = RES_ALU;
                w_pc_write   = 1'b1;
                w_reg_write  = w_funct[4];
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_BYTE_EN
    assign w_only_byte = ((r_state == S_MEMRD) || (r_state == S_MEMWR)) && w_funct[2];
`else
    assign w_only_byte = 1'b0;
`endif

    // Reset forces every output low at once, dropping any in-flight strobe
    assign PCWrite    = reset & w_pc_write;
    assign AdrSrc     = reset & w_adr_src;
    assign MemWrite   = reset & w_mem_write;
    assign MemRead    = reset & w_mem_read;
    assign IRWrite    = reset & w_ir_write;
    assign ResultSrc  = reset ? w_result_src  : '0;
    assign ALUSrcA    = reset & w_alu_src_a;
    assign ALUSrcB    = reset ? w_alu_src_b   : '0;
    assign ALUControl = reset ? w_alu_control : '0;
    assign ImmSrc     = reset ? w_op          : '0;
    assign RegSrc     = reset ? {w_op == OP_MEM, w_op == OP_BR} : '0;
    assign RegWrite   = reset & w_reg_write;
    assign OnlyByte   = reset & w_only_byte;

endmodule

// File: tb/tb_mc_controller.sv
// Directed + randomized bench for mc_controller with a per-instruction
// cycle-trace reference model.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = 20'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        MemReady = 1'b0;

    logic        PCWrite, AdrSrc, MemWrite, MemRead, IRWrite, ALUSrcA, RegWrite, OnlyByte;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [18:0] w_obs;

    int          checks = 0;
    int          failures = 0;
    logic [19:0] cur_ir = 20'h0;
    logic [3:0]  nzcv = 4'h0;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
        .OnlyByte(OnlyByte)
    );

    always #5 clk = ~clk;

    assign w_obs = {PCWrite, AdrSrc, MemWrite, MemRead, IRWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, OnlyByte};

    function automatic logic [18:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic mr, input logic irw, input logic [1:0] rs,
                                       input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [19:0] ir, input logic rw, input logic ob);
        logic [1:0] op;
        op = ir[15:14];
        return {pcw, adr, mw, mr, irw, rs, sa, sb, alu, op, (op == 2'b01), (op == 2'b10), rw, ob};
    endfunction

    function automatic logic [18:0] fetch_v(input logic [19:0] ir, input logic rdy);
        return ov(rdy, 1'b0, 1'b0, 1'b1, rdy, 2'b10, 1'b1, 2'b10, 3'b000, ir, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] decode_v(input logic [19:0] ir);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, ir, 1'b0, 1'b0);
    endfunction

    // Condition pairs: even code tests the base predicate, odd code its inverse
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic base;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic cyc(input logic [19:0] ir, input logic mr, input logic [3:0] fl,
                       input logic [18:0] ev, input string tag);
        @(negedge clk);
        Instr = ir;
        MemReady = mr;
        ALUFlags = fl;
        #1;
        checks++;
        assert (w_obs === ev) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, w_obs, ev);
        end
    endtask

    task automatic run(input logic [19:0] ins, input logic [3:0] exfl, input int fw,
                       input int mw, input string tag);
        logic [1:0] op;
        logic [5:0] fn;
        logic       pc, ob, wb, cv;
        logic [2:0] alu;
        op = ins[15:14];
        fn = ins[13:8];
        pc = (ins[3:0] == 4'hF);
`ifdef MC_CTRL_BYTE_EN
        ob = fn[2];
`else
        ob = 1'b0;
`endif
        for (int i = 0; i < fw; i++) cyc(cur_ir, 1'b0, 4'($urandom), fetch_v(cur_ir, 1'b0), {tag, "/fwait"});
        cyc(cur_ir, 1'b1, 4'($urandom), fetch_v(cur_ir, 1'b1), {tag, "/fetch"});
        cur_ir = ins;
        cyc(ins, 1'($urandom), 4'($urandom), decode_v(ins), {tag, "/decode"});
        if (!cond_ok(ins[19:16], nzcv)) return;
        case (op)
            2'b00: begin
                case (fn[4:1])
                    4'b0100: begin alu = 3'b000; wb = 1'b1; cv = 1'b1; end
                    4'b0010: begin alu = 3'b001; wb = 1'b1; cv = 1'b1; end
                    4'b0000: begin alu = 3'b010; wb = 1'b1; cv = 1'b0; end
                    4'b1100: begin alu = 3'b011; wb = 1'b1; cv = 1'b0; end
                    4'b0001: begin alu = 3'b100; wb = 1'b1; cv = 1'b0; end
                    4'b1010: begin alu = 3'b001; wb = 1'b0; cv = 1'b1; end
                    default: begin alu = 3'b000; wb = 1'b0; cv = 1'b0; end
                endcase
                cyc(ins, 1'($urandom), exfl,
                    ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, fn[5] ? 2'b01 : 2'b00, alu, ins, 1'b0, 1'b0),
                    {tag, "/exec"});
                if (fn[0]) begin
                    nzcv[3:2] = exfl[3:2];
                    if (cv) nzcv[1:0] = exfl[1:0];
                end
                if (wb)
                    cyc(ins, 1'($urandom), 4'($urandom),
                        ov(pc, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, ins, 1'b1, 1'b0),
                        {tag, "/aluwb"});
            end
            2'b01: begin
                cyc(ins, 1'($urandom), 4'($urandom),
                    ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, ins, 1'b0, 1'b0),
                    {tag, "/memadr"});
                if (fn[0]) begin
                    for (int i = 0; i <= mw; i++)
                        cyc(ins, (i == mw), 4'($urandom),
                            ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, ins, 1'b0, ob),
                            {tag, "/memrd"});
                    cyc(ins, 1'($urandom), 4'($urandom),
                        ov(pc, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000, ins, 1'b1, 1'b0),
                        {tag, "/memwb"});
                end else begin
                    for (int i = 0; i <= mw; i++)
                        cyc(ins, (i == mw), 4'($urandom),
                            ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, ins, 1'b0, ob),
                            {tag, "/memwr"});
                end
            end
            2'b10: cyc(ins, 1'($urandom), 4'($urandom),
                       ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 3'b000, ins, fn[4], 1'b0),
                       {tag, "/branch"});
            default: ;
        endcase
    endtask

    initial begin
        logic [19:0] ins;
        logic [3:0]  cmd;

        // Reset held: outputs silent even with MemReady high
        for (int i = 0; i < 3; i++) cyc(20'h2A5C3, 1'b1, 4'hF, 19'h0, "reset_hold");
        cur_ir = 20'h2A5C3;
        @(negedge clk);
        reset = 1'b1;
        MemReady = 1'b0;

        run(20'hE2821, 4'h0, 0, 0, "add_imm");
        run(20'hE0510, 4'b0100, 1, 0, "subs_z");
        run(20'h0A000, 4'h0, 0, 0, "beq_taken");
        run(20'hE0510, 4'b0000, 0, 0, "subs_nz");
        run(20'h0A000, 4'h0, 0, 0, "beq_skip");
        run(20'hE5912, 4'h0, 0, 2, "ldr_wait");
        run(20'hE591F, 4'h0, 0, 0, "ldr_pc");
        run(20'hE5C12, 4'h0, 0, 1, "strb");
        run(20'hE1510, 4'b1011, 0, 0, "cmp");
        run(20'hCA000, 4'h0, 0, 0, "bgt");
        run(20'hEB000, 4'h0, 2, 0, "bl");
        run(20'hF2821, 4'h0, 0, 0, "never");
        run(20'hEE000, 4'h0, 0, 0, "op11");
        run(20'hE281F, 4'h0, 0, 0, "add_pc");

        // Reset pulled mid-store: strobe dropped in the same cycle, restart in FETCH
        ins = 20'hE5812;
        cyc(cur_ir, 1'b1, 4'h0, fetch_v(cur_ir, 1'b1), "rst_str/fetch");
        cur_ir = ins;
        cyc(ins, 1'b0, 4'h0, decode_v(ins), "rst_str/decode");
        cyc(ins, 1'b0, 4'h0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, ins, 1'b0, 1'b0),
            "rst_str/memadr");
        cyc(ins, 1'b0, 4'h0, ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, ins, 1'b0, 1'b0),
            "rst_str/memwr");
        @(negedge clk);
        MemReady = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        assert (w_obs === 19'h0) else begin
            failures++;
            $error("FAIL rst_mid_memwr observed=%05h expected=%05h", w_obs, 19'h0);
        end
        nzcv = 4'h0;
        @(negedge clk);
        MemReady = 1'b0;
        reset = 1'b1;
        cyc(ins, 1'b0, 4'h0, fetch_v(ins, 1'b0), "post_rst_fetch");

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 1) == 1) ins[19:16] = 4'hE;
            cmd = ins[12:9];
            if (ins[15:14] == 2'b00 && !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010}))
                ins[8] = 1'b0;
            run(ins, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the ARM-subset core, replacing the single-cycle control path when instruction and data share one memory port. It holds the main FSM, the NZCV flag register and the condition check, and drives every enable and mux select of the multicycle datapath. It waits on a memory ready handshake, so the same core runs against single-cycle or multi-wait-state memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- Instr  in  20  IR bits [31:12]; valid from DECODE onward
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  memory completes access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALU result register as memory address
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read request
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00 ALUOut, 01 Data reg, 10 ALU direct
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 WriteData, 01 ExtImm, 10 constant 4
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
- ImmSrc  out  2  = Instr[27:26]
- RegSrc  out  2  {Op==01, Op==10}
- RegWrite  out  1  register file write enable
- OnlyByte  out  1  byte-wide memory access

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Hold until MemReady. In the MemReady cycle assert IRWrite and PCWrite, then go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, producing PC+8 for R15 reads. If the condition fails, go to FETCH with no side effects. Otherwise Op=00 goes to EXECI (Funct[5]=1) or EXECR. Op=01 goes to MEMADR. Op=10 goes to BRANCH. Op=11 goes to FETCH.
- Condition check: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL are evaluated against the flag register. Cond=1111 is treated as never.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00 (R) or 01 (I). Command decode from Funct[4:1]:
  - 0100 ADD
  - 0010 SUB
  - 0000 AND
  - 1100 ORR
  - 0001 EOR
  - 1010 CMP: SUB, no writeback
  - any other value: ADD, no writeback
- Flag register update, only when Funct[0]=1 and in EXEC: N,Z update always. C,V update only for ADD/SUB/CMP.
- EXEC goes to ALUWB, or to FETCH when there is no writeback.
- ALUWB: ResultSrc=00, RegWrite=1. If Rd=1111, PCWrite=1 too. Then FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 goes to MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, MemRead=1. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. If Rd=1111, PCWrite=1. Then FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Hold until MemReady, then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. If Funct[4]=1 (BL), also RegWrite=1 to R14; the datapath selects R14 via RegSrc. Then FETCH.
- Outputs are Moore per state, except the FETCH enables, which are gated by MemReady.

## Timing
- While reset=0: state=FETCH, flags=0000, every output 0.
- First fetch begins in the first cycle after reset rises.
- Cycle counts with zero-wait memory:
  - data-processing with writeback: 4
  - CMP/no-writeback: 3
  - LDR: 5
  - STR: 4
  - B/BL: 3
  - condition-failed: 2
- Each wait cycle (MemReady=0 in FETCH/MEMRD/MEMWR) adds one cycle. Outputs are held stable during waits.
- Flags written in EXEC are visible to the condition check of the next instruction's DECODE.
- Reset asserted mid-state aborts immediately. A pending MemWrite is dropped within the same cycle.

## Configuration
- MC_CTRL_BYTE_EN defined: OnlyByte = Funct[2] (B bit) during MEMRD and MEMWR, and 0 otherwise.
- Undefined: OnlyByte is tied to 0, and LDRB/STRB execute as word accesses.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state enum
  - ALUControl, ResultSrc and ALUSrcB encodings
  - condition-code constants
- One sub-module, mc_condcheck: combinational Cond × flags → CondEx, instantiated once.
- Flag register and FSM live in mc_controller.

## Test plan
- Reset low mid-MEMWR (MemWrite=1) → all outputs 0 that cycle; state is FETCH after reset rises.
- ADD R1,R2,#5 (Instr[31:12]=E2821), MemReady=1 → FETCH, DECODE, EXECI, ALUWB in 4 cycles; ALUControl=000; RegWrite=1 only in cycle 4.
- SUBS then BEQ, with ALUFlags=0100 during SUBS EXEC → Z latched; branch takes 3 cycles with PCWrite=1 in BRANCH. With ALUFlags=0000 → BEQ returns to FETCH after DECODE, no PCWrite.
- LDR with MemReady low for 2 cycles in MEMRD → MEMRD lasts 3 cycles, AdrSrc=1 held; MEMWB has ResultSrc=01 and RegWrite=1; total 7 cycles.
- LDR to PC (Rd=1111) → MEMWB asserts both RegWrite and PCWrite.
- STRB with MC_CTRL_BYTE_EN defined → OnlyByte=1 with MemWrite=1. Undefined → OnlyByte=0.
